// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the core execution sequencer.
// State codes are visible on the debug display, so they are fixed values.
package rv_ctrl_pkg;

   localparam int ST_W = 3;

   localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [ST_W-1:0] ST_RUN   = 3'd1;
   localparam logic [ST_W-1:0] ST_STEP  = 3'd2;
   localparam logic [ST_W-1:0] ST_HALT  = 3'd3;
   localparam logic [ST_W-1:0] ST_BREAK = 3'd4;

   typedef enum logic [ST_W-1:0] {
      S_IDLE  = ST_IDLE,
      S_RUN   = ST_RUN,
      S_STEP  = ST_STEP,
      S_HALT  = ST_HALT,
      S_BREAK = ST_BREAK
   } state_t;

endpackage

// File: rtl/go_sync.sv
// Push-button synchronizer with a single-clock rising-edge strobe.
// The edge detector only arms once the synced level has been seen low after reset.
module go_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic rise
);

   localparam int CW = $clog2(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   armed_q;
   logic [CW-1:0]          fill_cnt_q;
   logic                   sync_out;

   assign sync_out = sync_q[SYNC_STAGES-1];

   // A button held through reset release must not look like a fresh press,
   // so arming waits until the chain has filled and shows the released level.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q     <= '0;
         prev_q     <= 1'b0;
         armed_q    <= 1'b0;
         fill_cnt_q <= CW'(SYNC_STAGES);
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         prev_q <= sync_out;
         if (fill_cnt_q != '0)
            fill_cnt_q <= fill_cnt_q - CW'(1);
         else if (!sync_out)
            armed_q <= 1'b1;
      end
   end

   assign rise = armed_q && sync_out && !prev_q;

endmodule

// File: rtl/run_ctrl.sv
// Execution sequencer: turns rate ticks into single-clock commit enables,
// with start, ecall halt/resume, single-step and a PC breakpoint.
//
//   state | meaning
//   IDLE  | waiting for first go press after reset
//   RUN   | issue one commit per tick
//   STEP  | issue one commit per go press (on the following tick)
//   HALT  | stalled on an ecall, go resumes and commits it
//   BREAK | stalled on breakpoint PC, go resumes and commits it
module run_ctrl
   import rv_ctrl_pkg::*;
#(
   parameter int CYC_W       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             go,
   input  logic             step_mode,
   input  logic             halt_req,
   input  logic [31:0]      pc,
   input  logic             bp_en,
   input  logic [31:0]      bp_addr,
   output logic             cpu_en,
   output logic             pause,
   output logic [ST_W-1:0]  state,
   output logic [CYC_W-1:0] cycle
);

   logic             go_rise;
   logic             bp_hit;
   state_t           state_q, state_d;
   logic             ovr_q, ovr_d;
   logic             pend_q, pend_d;
   logic             issue;
   logic             en_q;
   logic [CYC_W-1:0] cycle_q;

   go_sync #(.SYNC_STAGES(SYNC_STAGES)) u_go_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (go),
      .rise     (go_rise)
   );

   assign bp_hit = bp_en && (pc == bp_addr);

   always_comb begin
      state_d = state_q;
      ovr_d   = ovr_q;
      pend_d  = pend_q;
      issue   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (go_rise) begin
               state_d = step_mode ? S_STEP : S_RUN;
               ovr_d   = 1'b0;
               pend_d  = 1'b0;
            end
         end
         S_RUN: begin
            if (step_mode) begin
               state_d = S_STEP;
               pend_d  = 1'b0;
            end else if (tick) begin
               if (halt_req && !ovr_q)    state_d = S_HALT;
               else if (bp_hit && !ovr_q) state_d = S_BREAK;
               else                       issue   = 1'b1;
            end
         end
         S_STEP: begin
            if (!step_mode) begin
               state_d = S_RUN;
            end else begin
               if (tick && pend_q) begin
                  if (halt_req && !ovr_q)    state_d = S_HALT;
                  else if (bp_hit && !ovr_q) state_d = S_BREAK;
                  else                       issue   = 1'b1;
               end
               if (issue) pend_d = 1'b0;
               // A press arriving with the commit queues the next step.
               if (go_rise) pend_d = 1'b1;
            end
         end
         S_HALT, S_BREAK: begin
            if (go_rise) begin
               state_d = step_mode ? S_STEP : S_RUN;
               ovr_d   = 1'b1;
               pend_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (issue) ovr_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         ovr_q   <= 1'b0;
         pend_q  <= 1'b0;
         en_q    <= 1'b0;
         cycle_q <= '0;
      end else begin
         state_q <= state_d;
         ovr_q   <= ovr_d;
         pend_q  <= pend_d;
         en_q    <= issue;
         if (issue) cycle_q <= cycle_q + CYC_W'(1);
      end
   end

   assign cpu_en = en_q;
   assign pause  = !((state_q == S_RUN) || (state_q == S_STEP));
   assign state  = state_q;
   assign cycle  = cycle_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: start, halt/resume, breakpoint, single-step,
// halt-over-break priority and reset dropping a pending commit.
module tb_run_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        tick = 1'b0;
   logic        go = 1'b0;
   logic        step_mode = 1'b0;
   logic        halt_req = 1'b0;
   logic [31:0] pc = '0;
   logic        bp_en = 1'b0;
   logic [31:0] bp_addr = '0;
   logic        cpu_en;
   logic        pause;
   logic [2:0]  state;
   logic [31:0] cycle;

   int checks = 0;
   int errors = 0;
   logic en;

   run_ctrl #(.CYC_W(32), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .go        (go),
      .step_mode (step_mode),
      .halt_req  (halt_req),
      .pc        (pc),
      .bp_en     (bp_en),
      .bp_addr   (bp_addr),
      .cpu_en    (cpu_en),
      .pause     (pause),
      .state     (state),
      .cycle     (cycle)
   );

   always #5 clk = ~clk;

   // Contract: a tick never lands while a commit is in flight.
   always @(posedge clk) begin
      if (rst) begin
         assert (!(tick && cpu_en)) else begin
            errors++;
            $error("FAIL tick_while_cpu_en: observed tick=1 cpu_en=1 expected not both");
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0; tick = 1'b0; go = 1'b0; step_mode = 1'b0; halt_req = 1'b0;
      pc = '0; bp_en = 1'b0; bp_addr = '0;
      repeat (3) @(negedge clk);
      check("rst_state", 32'(state), 32'd0);
      check("rst_cpu_en", 32'(cpu_en), 32'd0);
      check("rst_pause", 32'(pause), 32'd1);
      check("rst_cycle", cycle, 32'd0);
      rst = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   // go held for 3 clocks: the state must have moved by the third negedge
   task automatic press_go();
      @(negedge clk) go = 1'b1;
      repeat (3) @(negedge clk);
      go = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // 10-clock tick period; returns cpu_en seen one clock after the tick
   task automatic do_tick(output logic en_seen);
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
      en_seen = cpu_en;
      @(negedge clk);
      check("cpu_en_one_clk", 32'(cpu_en), 32'd0);
      repeat (7) @(negedge clk);
   endtask

   initial begin
      // 1: start and free run
      do_reset();
      @(negedge clk) go = 1'b1;
      repeat (3) @(negedge clk);
      check("t1_start_3clk", 32'(state), 32'd1);
      go = 1'b0;
      repeat (3) @(negedge clk);
      check("t1_pause", 32'(pause), 32'd0);
      for (int i = 1; i <= 5; i++) begin
         do_tick(en);
         check("t1_issue", 32'(en), 32'd1);
         check("t1_cycle", cycle, 32'(i));
      end

      // 2: ecall halt then resume
      do_reset();
      press_go();
      for (int i = 0; i < 3; i++) do_tick(en);
      halt_req = 1'b1;
      do_tick(en);
      check("t2_no_issue", 32'(en), 32'd0);
      check("t2_state_halt", 32'(state), 32'd3);
      check("t2_pause", 32'(pause), 32'd1);
      check("t2_cycle_frozen", cycle, 32'd3);
      press_go();
      check("t2_resume_state", 32'(state), 32'd1);
      do_tick(en);
      check("t2_ecall_commit", 32'(en), 32'd1);
      check("t2_cycle", cycle, 32'd4);
      check("t2_state_run", 32'(state), 32'd1);
      halt_req = 1'b0;

      // 3: breakpoint at 0x10
      do_reset();
      bp_en = 1'b1; bp_addr = 32'h10;
      press_go();
      pc = 32'h8;  do_tick(en); check("t3_issue_8", 32'(en), 32'd1);
      pc = 32'hC;  do_tick(en); check("t3_issue_c", 32'(en), 32'd1);
      pc = 32'h10; do_tick(en); check("t3_bp_no_issue", 32'(en), 32'd0);
      check("t3_state_break", 32'(state), 32'd4);
      press_go();
      check("t3_resume", 32'(state), 32'd1);
      do_tick(en); check("t3_bp_commit", 32'(en), 32'd1);
      check("t3_cycle3", cycle, 32'd3);
      pc = 32'h14; do_tick(en); check("t3_issue_14", 32'(en), 32'd1);
      pc = 32'h10; do_tick(en); check("t3_bp_again", 32'(en), 32'd0);
      check("t3_state_break2", 32'(state), 32'd4);
      check("t3_cycle4", cycle, 32'd4);

      // 4: single-step
      do_reset();
      press_go();
      @(negedge clk) step_mode = 1'b1;
      @(negedge clk);
      check("t4_state_step", 32'(state), 32'd2);
      for (int i = 0; i < 3; i++) begin
         do_tick(en);
         check("t4_no_go_no_issue", 32'(en), 32'd0);
      end
      check("t4_cycle0", cycle, 32'd0);
      press_go();
      do_tick(en); check("t4_step_issue", 32'(en), 32'd1);
      do_tick(en); check("t4_second_tick", 32'(en), 32'd0);
      check("t4_cycle1", cycle, 32'd1);
      check("t4_state", 32'(state), 32'd2);
      step_mode = 1'b0;

      // 5: ecall and breakpoint on the same tick
      do_reset();
      press_go();
      bp_en = 1'b1; bp_addr = 32'h10; pc = 32'h10; halt_req = 1'b1;
      do_tick(en);
      check("t5_no_issue", 32'(en), 32'd0);
      check("t5_halt_wins", 32'(state), 32'd3);
      halt_req = 1'b0; bp_en = 1'b0;

      // 6: reset between tick and cpu_en, go held across release
      do_reset();
      press_go();
      do_tick(en);
      check("t6_pre_cycle", cycle, 32'd1);
      @(negedge clk) tick = 1'b1;
      #2 rst = 1'b0;
      @(negedge clk) tick = 1'b0;
      check("t6_cpu_en_dropped", 32'(cpu_en), 32'd0);
      check("t6_cycle", cycle, 32'd0);
      check("t6_state", 32'(state), 32'd0);
      go = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      check("t6_held_go_no_start", 32'(state), 32'd0);
      go = 1'b0;
      repeat (4) @(negedge clk);
      check("t6_release_no_start", 32'(state), 32'd0);
      press_go();
      check("t6_new_press_start", 32'(state), 32'd1);
      do_tick(en);
      check("t6_issue", 32'(en), 32'd1);
      check("t6_cycle1", cycle, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Execution sequencer for the single-cycle RISC-V core.
- Replaces per-rate gated clocks with one system clock and a single-cycle commit enable `cpu_en`; PC, RegFile, DMem, LedLatch and the cycle counter advance only when `cpu_en` = 1.
- Handles start (go), ecall halt/resume, single-step and a hardware PC breakpoint, and counts committed instructions for the display mux.

Parameters:
- CYC_W, 32, width of committed-instruction counter.
- SYNC_STAGES, 2, flops in the go synchronizer (≥2).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-low reset.
- tick, in, 1, one-clk strobe at the selected execution rate (1/10/50/100 Hz divider output).
- go, in, 1, asynchronous push-button level.
- step_mode, in, 1, 1 = single-step, 0 = free run.
- halt_req, in, 1, combinational: current instruction is a non-LED ecall.
- pc, in, 32, current PC.
- bp_en, in, 1, breakpoint enable.
- bp_addr, in, 32, breakpoint PC (word aligned).
- cpu_en, out, 1, commit enable, registered, one clk wide.
- pause, out, 1, 1 in every state except RUN/STEP.
- state, out, 3, FSM state code.
- cycle, out, CYC_W, committed instructions.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, cpu_en = 0, pause = 1, cycle = 0.
  - ovr = 0, step_pend = 0, sync chain cleared.
- go path: SYNC_STAGES-flop synchronizer, then rising-edge detect gives `go_rise`, one clk wide. Holding go generates no repeat pulses.
- States (codes from package): IDLE = 0, RUN = 1, STEP = 2, HALT = 3, BREAK = 4.
- bp_hit = bp_en && (pc == bp_addr).
- Issue condition, evaluated on a tick cycle:
  - ok = (!halt_req || ovr) && (!bp_hit || ovr).
  - RUN issues when ok.
  - STEP issues when ok && step_pend.
- Issue effects:
  - cpu_en = 1 in the next clk; latency tick→cpu_en is 1 clk.
  - cycle += 1 in the same clk as cpu_en (wraps modulo 2^CYC_W).
  - ovr and step_pend clear.
- Transitions:
  - IDLE: go_rise → STEP if step_mode, else RUN. ovr = 0.
  - RUN:
    - tick && halt_req && !ovr → HALT, no issue.
    - tick && bp_hit && !ovr → BREAK, no issue. If both, HALT wins.
    - step_mode = 1 sampled on any clk → STEP with step_pend = 0.
  - STEP:
    - go_rise sets step_pend.
    - Halt/breakpoint checks as in RUN, but only when step_pend = 1.
    - step_mode = 0 → RUN.
  - HALT / BREAK: go_rise → RUN or STEP (per step_mode) with ovr = 1 and step_pend = 1, so the stalled ecall or breakpoint instruction commits on the next tick.
- Simultaneous events:
  - go_rise and tick in the same clk: the transition takes effect, and the issue waits for the next tick.
  - A tick that arrives while cpu_en is already 1 is impossible by contract (tick period ≥ 2 clk); the bench asserts this.
- pc and halt_req are sampled only on tick cycles; changes between ticks are ignored.
- Reset mid-run: all outputs return to reset values immediately. A pending cpu_en is dropped, and no partial commit is visible.

Decomposition:
- Package rv_ctrl_pkg:
  - state encoding localparams ST_IDLE..ST_BREAK.
  - state width constant ST_W = 3.
- Sub-module go_sync:
  - synchronizer chain plus edge detector.
  - parameter SYNC_STAGES.
  - ports clk, rst, async_in, rise.

Test Plan:
1. Reset, then go pulse, step_mode = 0, tick every 10 clk, halt_req = 0 → state 0→1 within 3 clk; cpu_en high 1 clk after each tick; cycle = 5 after 5 ticks; pause = 0.
2. RUN; halt_req = 1 on 4th tick → no cpu_en that tick; state = 3; pause = 1; cycle frozen at 3. Then go pulse → next tick issues, cycle = 4, state = 1.
3. bp_en = 1, bp_addr = 0x0000_0010, pc reaches 0x10 → state = 4, no issue at 0x10. Go → 0x10 commits once; a later return to 0x10 breaks again.
4. step_mode = 1 after start, three ticks with no go → no cpu_en. Go pulse, then 2 ticks → exactly one cpu_en on the first tick; cycle +1.
5. halt_req = 1 and bp_hit on the same tick → state = 3 (HALT), not BREAK.
6. Assert rst = 0 in the clk between a tick and cpu_en → cpu_en stays 0, cycle = 0, state = 0. Go held high across reset release produces no start until it is released and pressed again.
